// File: rtl/ysyx_22040632_booth_mul_seq_if.sv
// ----------------------------------------------------------------------------
// ysyx_22040632_booth_mul_seq_if
//
// Purpose : operand/result handshake bundle for the iterative radix-4 Booth
//           multiplier. Clock, reset and flush stay plain ports on the block.
//
// Signals : in_valid / in_ready   operand handshake
//           in_x, in_y            multiplicand / multiplier, W bits
//           x_signed, y_signed    1 = operand is two's complement
//           out_valid / out_ready product handshake
//           out_p                 full 2W-bit product
//
// Modports: master - the producer of operands and consumer of products
//           slave  - the multiplier
// ----------------------------------------------------------------------------
interface ysyx_22040632_booth_mul_seq_if #(
    parameter int W = 64
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_x;
    logic [W-1:0]   in_y;
    logic           x_signed;
    logic           y_signed;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_p;

    modport master (
        output in_valid, in_x, in_y, x_signed, y_signed, out_ready,
        input  in_ready, out_valid, out_p
    );

    modport slave (
        input  in_valid, in_x, in_y, x_signed, y_signed, out_ready,
        output in_ready, out_valid, out_p
    );
endinterface

// File: rtl/ysyx_22040632_booth_mul_seq.sv
// ----------------------------------------------------------------------------
// ysyx_22040632_booth_mul_seq
//
// Purpose : iterative radix-4 Booth multiplier for the EXU multiply path.
//           Retires DIGITS Booth digits per cycle into a 2W-bit accumulator.
//           Each operand is independently signed or unsigned, which covers
//           MUL / MULH / MULHSU / MULHU (low W bits = MUL, high W = MULH*).
//
// Parameters:
//   W      operand width, even and >= 8
//   DIGITS Booth digits retired per cycle: 1, 2 or 4
//
// Ports:
//   clock  system clock
//   reset  synchronous, active-high reset
//   flush  abort the current operation (highest priority after reset)
//   bus    slave side of ysyx_22040632_booth_mul_seq_if (valid/ready in and
//          out, operands, signedness flags, product)
//
// Build option:
//   YSYX_22040632_MUL_EARLY_TERM_EN - when defined, BUSY ends as soon as all
//   still-unretired multiplier bits (overlap bit included) are all-0 or
//   all-1, since every remaining Booth digit is then zero. Without it the
//   latency is fixed at ceil((W+2)/2 / DIGITS) + 1 cycles.
// ----------------------------------------------------------------------------
module ysyx_22040632_booth_mul_seq #(
    parameter int W      = 64,
    parameter int DIGITS = 1
) (
    input logic                          clock,
    input logic                          reset,
    input logic                          flush,
    ysyx_22040632_booth_mul_seq_if.slave bus
);
    // Operands are extended to E = W+2 bits so an unsigned W-bit multiplier
    // still has a zero sign bit and the top digit triple is well formed.
    localparam int E  = W + 2;
    localparam int N  = E / 2;
    localparam int PW = 2 * W;
    localparam int CW = $clog2(N + DIGITS + 1);
    localparam logic [PW-1:0] ONE = PW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t          r_state;
    logic            r_in_ready;
    logic            r_out_valid;
    logic [PW-1:0]   r_acc;
    // Multiplicand, pre-shifted to the weight of the next digit to retire.
    logic [PW-1:0]   r_x;
    // Multiplier with the overlap bit y[-1] at position 0; shifted right by
    // 2*DIGITS each BUSY cycle so the current digits always sit at the bottom.
    logic [E:0]      r_y;
    logic [CW-1:0]   r_cnt;

    logic [PW-1:0]   w_sum;
    logic            w_last;

    // One radix-4 Booth partial product for triple t = {y[2i+1], y[2i], y[2i-1]}.
    // Negation is invert-plus-one, done in full 2W arithmetic so the carry-in
    // lands at the digit weight already folded into mc.
    function automatic logic [PW-1:0] booth_pp(input logic [PW-1:0] mc,
                                               input logic [2:0]    t);
        case (t)
            3'b001, 3'b010: booth_pp = mc;
            3'b011:         booth_pp = mc << 1;
            3'b100:         booth_pp = ~(mc << 1) + ONE;
            3'b101, 3'b110: booth_pp = ~mc + ONE;
            default:        booth_pp = '0;
        endcase
    endfunction

    always_comb begin
        w_sum = r_acc;
        for (int j = 0; j < DIGITS; j++) begin
            w_sum = w_sum + booth_pp(r_x << (2 * j), r_y[2 * j +: 3]);
        end
    end

    // Digits past N read sign-fill bits of r_y (all-0 or all-1 triples), so
    // they contribute zero without any explicit masking.
`ifdef YSYX_22040632_MUL_EARLY_TERM_EN
    logic [E-2*DIGITS:0] w_rest;

    // Bits that would feed the digits of later cycles, overlap bit included.
    assign w_rest = r_y[E:2*DIGITS];
    assign w_last = (r_cnt + CW'(DIGITS) >= CW'(N)) || (&w_rest) || !(|w_rest);
`else
    assign w_last = (r_cnt + CW'(DIGITS) >= CW'(N));
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_cnt       <= '0;
        end else if (flush) begin
            // Datapath registers are left as they are; the result is dropped
            // simply by never raising out_valid for it.
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // in_ready is 1 here, so in_valid alone is the handshake.
                    if (bus.in_valid) begin
                        r_state    <= S_BUSY;
                        r_in_ready <= 1'b0;
                        r_acc      <= '0;
                        r_x        <= {{W{bus.x_signed & bus.in_x[W-1]}}, bus.in_x};
                        r_y        <= {{2{bus.y_signed & bus.in_y[W-1]}}, bus.in_y, 1'b0};
                        r_cnt      <= '0;
                    end
                end
                S_BUSY: begin
                    r_acc <= w_sum;
                    r_x   <= r_x << (2 * DIGITS);
                    r_y   <= {{(2 * DIGITS){r_y[E]}}, r_y[E:2*DIGITS]};
                    r_cnt <= r_cnt + CW'(DIGITS);
                    if (w_last) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    // The accumulator doubles as the product register; it only changes in
    // BUSY or on accept, so it is stable while out_valid is high.
    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_p     = r_acc;

endmodule

// File: tb/tb_ysyx_22040632_booth_mul_seq.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22040632_booth_mul_seq
//
// Drives three multipliers (W=64, DIGITS = 1, 2, 4) in lockstep with the same
// operands. A reference model computes each product as plain 128-bit
// arithmetic on the extended operands and each latency from the digit count;
// one process compares in_ready, out_valid and out_p of every instance with
// the model on every cycle.
// ----------------------------------------------------------------------------
module tb_ysyx_22040632_booth_mul_seq;

    logic         clock = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic [63:0]  in_x;
    logic [63:0]  in_y;
    logic         x_signed;
    logic         y_signed;
    logic         out_ready [3];
    logic         in_ready  [3];
    logic         out_valid [3];
    logic [127:0] out_p     [3];

    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : gd
        localparam int DG = (g == 0) ? 1 : (g == 1) ? 2 : 4;

        ysyx_22040632_booth_mul_seq_if #(.W(64)) u_if ();

        assign u_if.in_valid  = in_valid;
        assign u_if.in_x      = in_x;
        assign u_if.in_y      = in_y;
        assign u_if.x_signed  = x_signed;
        assign u_if.y_signed  = y_signed;
        assign u_if.out_ready = out_ready[g];
        assign in_ready[g]    = u_if.in_ready;
        assign out_valid[g]   = u_if.out_valid;
        assign out_p[g]       = u_if.out_p;

        ysyx_22040632_booth_mul_seq #(.W(64), .DIGITS(DG)) u_dut (
            .clock (clock),
            .reset (reset),
            .flush (flush),
            .bus   (u_if)
        );
    end

    int           n_chk = 0;
    int           n_pass = 0;
    int           cyc = 0;
    int           rdy_mode = 1;  // 0: out_ready low, 1: high, 2: random
    bit           armed = 1'b0;
    bit           post_rst = 1'b0;
    bit           pending  [3];
    bit           seen_ov  [3];
    int           acc_cyc  [3];
    int           lat      [3];
    int           meas_lat [3];
    int           n_done   [3];
    logic [127:0] exp_p    [3];
    logic [127:0] last_p   [3];

    function automatic int dig_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : 4;
    endfunction

    task automatic chk(input string name, input int k,
                       input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s dut=DIGITS%0d got=%h expected=%h", name, dig_of(k), got, exp);
    endtask

    // Mathematical product of the interpreted operands, mod 2^128.
    function automatic logic [127:0] ref_mul(input logic [63:0] x, input logic [63:0] y,
                                             input bit xs, input bit ys);
        logic [127:0] xe, ye;
        xe = xs ? {{64{x[63]}}, x} : {64'd0, x};
        ye = ys ? {{64{y[63]}}, y} : {64'd0, y};
        return xe * ye;
    endfunction

    // Accept-to-out_valid distance in cycles: 33 digits, d per cycle, +1.
    function automatic int lat_of(input int d, input logic [63:0] y, input bit ys);
        int c_full;
`ifdef YSYX_22040632_MUL_EARLY_TERM_EN
        logic [65:0] ye;
        bit all0, all1;
`endif
        c_full = (33 + d - 1) / d;
`ifdef YSYX_22040632_MUL_EARLY_TERM_EN
        ye = ys ? {{2{y[63]}}, y} : {2'b00, y};
        for (int c = 1; c < c_full; c++) begin
            all0 = 1'b1;
            all1 = 1'b1;
            for (int b = 2 * d * c - 1; b < 66; b++) begin
                if (ye[b]) all0 = 1'b0;
                else       all1 = 1'b0;
            end
            if (all0 || all1) return c + 1;
        end
`else
        if (ys && y[63]) c_full = c_full + 0;
`endif
        return c_full + 1;
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // Compare outputs with the model, then advance the model on this cycle's inputs.
    initial begin
        bit ov;
        forever begin
            @(negedge clock);
            if (armed) begin
                for (int k = 0; k < 3; k++) begin
                    ov = pending[k] && (cyc >= acc_cyc[k] + lat[k]);
                    chk("in_ready", k, in_ready[k], !pending[k]);
                    chk("out_valid", k, out_valid[k], ov);
                    if (ov) chk("out_p", k, out_p[k], exp_p[k]);
                    if (post_rst) chk("out_p_after_reset", k, out_p[k], 128'd0);
                end
            end
            post_rst = reset;
            if (reset) begin
                armed = 1'b1;
                for (int k = 0; k < 3; k++) pending[k] = 1'b0;
            end else if (flush) begin
                for (int k = 0; k < 3; k++) pending[k] = 1'b0;
            end else begin
                for (int k = 0; k < 3; k++) begin
                    if (!pending[k]) begin
                        if (in_valid) begin
                            pending[k] = 1'b1;
                            seen_ov[k] = 1'b0;
                            acc_cyc[k] = cyc;
                            lat[k]     = lat_of(dig_of(k), in_y, y_signed);
                            exp_p[k]   = ref_mul(in_x, in_y, x_signed, y_signed);
                        end
                    end else begin
                        ov = (cyc >= acc_cyc[k] + lat[k]);
                        if (out_valid[k] && !seen_ov[k]) begin
                            seen_ov[k]  = 1'b1;
                            meas_lat[k] = cyc - acc_cyc[k];
                        end
                        if (ov && out_ready[k]) begin
                            pending[k] = 1'b0;
                            last_p[k]  = out_p[k];
                            n_done[k]++;
                        end
                    end
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 3; k++) out_ready[k] = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            for (int k = 0; k < 3; k++)
                out_ready[k] = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    task automatic start_op(input logic [63:0] x, input logic [63:0] y, input bit xs, input bit ys);
        int t;
        t = 0;
        while (!(in_ready[0] && in_ready[1] && in_ready[2]) && t < 50) begin
            @(posedge clock);
            #1;
            t++;
        end
        chk("ready_wait", 0, {in_ready[0], in_ready[1], in_ready[2]}, 3'b111);
        in_x     = x;
        in_y     = y;
        x_signed = xs;
        y_signed = ys;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int base [3];
        int t;
        for (int k = 0; k < 3; k++) base[k] = n_done[k];
        t = 0;
        while (!(n_done[0] > base[0] && n_done[1] > base[1] && n_done[2] > base[2]) && t < 400) begin
            @(posedge clock);
            #1;
            t++;
        end
        chk("done_wait", 0, {n_done[0] > base[0], n_done[1] > base[1], n_done[2] > base[2]}, 3'b111);
    endtask

    task automatic directed(input logic [63:0] x, input logic [63:0] y, input bit xs, input bit ys,
                            input logic [127:0] lit, input string name);
        start_op(x, y, xs, ys);
        wait_done();
        for (int k = 0; k < 3; k++) chk(name, k, last_p[k], lit);
    endtask

    function automatic logic [63:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            4:       return 64'($urandom_range(0, 15));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        int t;
        reset    = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_x     = '0;
        in_y     = '0;
        x_signed = 1'b0;
        y_signed = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        directed(64'd3, 64'd5, 1'b0, 1'b0, 128'd15, "u_3x5");
        for (int k = 0; k < 3; k++) begin
`ifdef YSYX_22040632_MUL_EARLY_TERM_EN
            chk("latency_3x5", k, meas_lat[k], lat_of(dig_of(k), 64'd5, 1'b0));
`else
            chk("latency_3x5", k, meas_lat[k], (k == 0) ? 34 : (k == 1) ? 18 : 10);
`endif
        end
        directed('1, '1, 1'b1, 1'b1, 128'd1, "s_m1_x_m1");
        directed('1, '1, 1'b0, 1'b0, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, "u_max_x_max");
        directed(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b1,
                 128'h4000_0000_0000_0000_0000_0000_0000_0000, "s_min_sq");
        directed('1, 64'd2, 1'b1, 1'b0, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, "su_m1_x_2");

        // Back-pressure: product must hold in DONE while out_ready is low.
        rdy_mode = 0;
        start_op(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0);
        t = 0;
        while (!(out_valid[0] && out_valid[1] && out_valid[2]) && t < 100) begin
            @(posedge clock);
            #1;
            t++;
        end
        chk("reach_done", 0, {out_valid[0], out_valid[1], out_valid[2]}, 3'b111);
        repeat (10) @(posedge clock);
        #1;
        rdy_mode = 1;
        wait_done();

        // Flush in BUSY: nothing may come out, next op must be clean.
        rdy_mode = 0;
        start_op(64'hDEAD_BEEF_CAFE_F00D, 64'h7654_3210_7654_3210, 1'b0, 1'b1);
        repeat (4) @(posedge clock);
        #1;
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush    = 1'b0;
        rdy_mode = 1;
        @(posedge clock);
        #1;
        directed(64'd7, 64'hFFFF_FFFF_FFFF_FFFA, 1'b1, 1'b1,
                 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFD6, "s_7_x_m6");

        rdy_mode = 2;
        for (int i = 0; i < 1000; i++) begin
            logic [63:0] rx, ry;
            rx = rnd_op();
            ry = rnd_op();
            start_op(rx, ry, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (i == 500) begin
                repeat (3) @(posedge clock);
                #1;
                reset = 1'b1;
                repeat (2) @(posedge clock);
                #1;
                reset = 1'b0;
            end else begin
                wait_done();
            end
        end
        rdy_mode = 1;
        repeat (3) @(posedge clock);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
